pipelined_adder_sub: RTL

- Parametrised, pipelined successor to the 4-bit ripple-carry adder. Adds or subtracts two WIDTH-bit operands.
- The carry chain is split into STAGES equal ripple segments, with one register boundary per segment.
- Valid/ready handshake on both sides, so it sits directly in datapath streams and gives full throughput of one operation per cycle.

---
 rtl/pipelined_adder_sub.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pipelined_adder_sub.sv
// pipelined_adder_sub
//   Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into STAGES
//   equal ripple segments of C = WIDTH/STAGES bits, and each segment has one
//   register boundary. Segment k adds operand bits [(k+1)*C-1 : k*C] using
//   the carry registered by segment k-1. Finished low result bits travel
//   forward in the stage registers. Operand bits that are not yet consumed
//   are delayed beside them.
//   A single global advance enable (adv) moves the whole pipeline forward.
//   Bubbles travel through the stages as valid=0.
//
//   WIDTH must be >= 2 and an exact multiple of STAGES.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (clears valids, sum, cout, ovf)
//   in_valid   operand beat valid
//   in_ready   beat can be accepted this cycle (= !out_valid || out_ready)
//   a, b       operands
//   cin        carry-in, add mode only
//   sub        0: a+b+cin   1: a-b (a + ~b + 1)
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   sum        result
//   cout       carry out of the MSB (in sub mode, 1 = no borrow)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
module pipelined_adder_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int C = WIDTH / STAGES;

    logic adv;
    logic ovf_q;
    logic ovf_d;

    // The whole pipeline moves when the output slot is empty or being drained.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign ovf      = ovf_q;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // IN_W: operand bits that are still unconsumed on entry to this segment.
            // DONE_W: result bits that are final after this segment.
            localparam int IN_W   = WIDTH - gi * C;
            localparam int DONE_W = (gi + 1) * C;

            logic              src_valid;
            logic              src_carry;
            logic [IN_W-1:0]   src_a;
            logic [IN_W-1:0]   src_b;
            logic [C:0]        seg;
            logic [DONE_W-1:0] sum_new;

            logic              valid_q;
            logic              valid_d;
            logic              carry_q;
            logic              carry_d;
            logic [DONE_W-1:0] sum_q;
            logic [DONE_W-1:0] sum_d;

            if (gi == 0) begin : g_src
                // Subtraction is a + ~b + 1. cin is ignored in that mode.
                assign src_valid = in_valid && adv;
                assign src_carry = sub | cin;
                assign src_a     = a;
                assign src_b     = b ^ {WIDTH{sub}};
                assign sum_new   = seg[C-1:0];
            end else begin : g_src
                assign src_valid = g_stage[gi-1].valid_q;
                assign src_carry = g_stage[gi-1].carry_q;
                assign src_a     = g_stage[gi-1].g_tail.a_rem_q;
                assign src_b     = g_stage[gi-1].g_tail.b_rem_q;
                assign sum_new   = {seg[C-1:0], g_stage[gi-1].sum_q};
            end

            // This segment adds the low C bits of the operands that are still
            // waiting. The extra MSB of seg is the carry out of the segment.
            assign seg = {1'b0, src_a[C-1:0]} + {1'b0, src_b[C-1:0]} + {{C{1'b0}}, src_carry};

            always_comb begin
                valid_d = valid_q;
                carry_d = carry_q;
                sum_d   = sum_q;
                if (adv) begin
                    valid_d = src_valid;
                    carry_d = seg[C];
                    sum_d   = sum_new;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    carry_q <= 1'b0;
                    sum_q   <= '0;
                end else begin
                    valid_q <= valid_d;
                    carry_q <= carry_d;
                    sum_q   <= sum_d;
                end
            end

            if (gi < STAGES - 1) begin : g_tail
                // Upper operand bits that later segments still need. They ride
                // along with this beat.
                localparam int REM_W = IN_W - C;

                logic [REM_W-1:0] a_rem_q;
                logic [REM_W-1:0] a_rem_d;
                logic [REM_W-1:0] b_rem_q;
                logic [REM_W-1:0] b_rem_d;

                always_comb begin
                    a_rem_d = a_rem_q;
                    b_rem_d = b_rem_q;
                    if (adv) begin
                        a_rem_d = src_a[IN_W-1:C];
                        b_rem_d = src_b[IN_W-1:C];
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_rem_q <= '0;
                        b_rem_q <= '0;
                    end else begin
                        a_rem_q <= a_rem_d;
                        b_rem_q <= b_rem_d;
                    end
                end
            end else begin : g_last
                // The carry into the MSB is recovered from the MSB sum bit:
                // s = a ^ b ^ c_in, so c_in = a ^ b ^ s.
                always_comb begin
                    ovf_d = ovf_q;
                    if (adv) begin
                        ovf_d = (src_a[C-1] ^ src_b[C-1] ^ seg[C-1]) ^ seg[C];
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        ovf_q <= 1'b0;
                    end else begin
                        ovf_q <= ovf_d;
                    end
                end

                assign out_valid = valid_q;
                assign sum       = sum_q;
                assign cout      = carry_q;
            end
        end
    endgenerate
endmodule
